// File: rtl/spi_display_receiver.sv
// spi_display_receiver: MAX7219-compatible SPI display peripheral (mode 0, CS active-low, MSB first)
// Ports: clk/res (async active-low), ena, clk_SPI/CS/MOSI serial bus; digits/decode_mode/intensity/
// scan_limit/shutdown_n/display_test register file; frame_valid/frame_error pulses, frame_addr/frame_data
module spi_display_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ena,
  input  logic        clk_SPI,
  input  logic        CS,
  input  logic        MOSI,
  output logic [63:0] digits,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic        frame_valid,
  output logic [3:0]  frame_addr,
  output logic [7:0]  frame_data,
  output logic        frame_error
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
  logic sck_d, cs_d, sck, cs, mosi, sck_rise, cs_rise, cs_fall;
  logic start, shift, commit, err;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [4:0] count;
  logic [3:0] addr;
  logic [7:0] data;
  assign sck      = sck_s[SYNC_STAGES-1];
  assign cs       = cs_s[SYNC_STAGES-1];
  assign mosi     = mosi_s[SYNC_STAGES-1];
  assign sck_rise = sck & ~sck_d;
  assign cs_rise  = cs & ~cs_d;
  assign cs_fall  = ~cs & cs_d;
  assign addr     = shift_reg[11:8];
  assign data     = shift_reg[7:0];
  // Sync chains reset low so a CS already low when reset releases is never seen as a frame start.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sck_s  <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
      sck_d  <= 1'b0;
      cs_d   <= 1'b0;
      state  <= IDLE;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-2:0], clk_SPI};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], CS};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], MOSI};
      sck_d  <= sck;
      cs_d   <= cs;
      state  <= state_nx;
    end
  end
  // A clk_SPI rise coinciding with the CS rise is dropped: the frame is judged on the prior count.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    shift    = 1'b0;
    commit   = 1'b0;
    err      = 1'b0;
    if (state == IDLE) begin
      start    = cs_fall & ena;
      state_nx = start ? RECV : IDLE;
    end else if (!ena) begin
      state_nx = IDLE;
    end else if (cs_rise) begin
      state_nx = IDLE;
      commit   = count == 5'(FRAME_BITS);
      err      = count != 5'(FRAME_BITS);
    end else begin
      shift = sck_rise;
    end
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      shift_reg    <= '0;
      count        <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      frame_addr   <= '0;
      frame_data   <= '0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
    end else begin
      frame_valid <= commit;
      frame_error <= err;
      if (start) begin
        shift_reg <= '0;
        count     <= '0;
      end else if (shift) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi};
        count     <= (count == 5'd31) ? count : count + 5'd1;
      end
      if (commit) begin
        frame_addr <= addr;
        frame_data <= data;
        for (int i = 0; i < 8; i++)
          if (addr == 4'(i + 1)) digits[8*i +: 8] <= data;
        if (addr == 4'h9) decode_mode <= data;
        if (addr == 4'hA) intensity <= data[3:0];
        if (addr == 4'hB) scan_limit <= data[2:0];
        if (addr == 4'hC) shutdown_n <= data[0];
        if (addr == 4'hF) display_test <= data[0];
      end
    end
  end
endmodule

// File: tb/tb_spi_display_receiver.sv
// tb_spi_display_receiver: table-driven frame vectors plus hand sequences for reset and CS/clk_SPI clash
module tb_spi_display_receiver;
  logic clk = 0, res = 0, ena = 1, clk_SPI = 0, CS = 1, MOSI = 0;
  logic [63:0] digits;
  logic [7:0] decode_mode, frame_data;
  logic [3:0] intensity, frame_addr;
  logic [2:0] scan_limit;
  logic shutdown_n, display_test, frame_valid, frame_error;
  int checks = 0, failures = 0, vcnt = 0, ecnt = 0;

  spi_display_receiver dut (
    .clk(clk), .res(res), .ena(ena), .clk_SPI(clk_SPI), .CS(CS), .MOSI(MOSI),
    .digits(digits), .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
    .shutdown_n(shutdown_n), .display_test(display_test), .frame_valid(frame_valid),
    .frame_addr(frame_addr), .frame_data(frame_data), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) vcnt++;
    if (frame_error) ecnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [16:0] ctl();
    return {decode_mode, intensity, scan_limit, shutdown_n, display_test};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [16:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      MOSI = v[i];
      repeat (4) @(negedge clk);
      clk_SPI = 1;
      repeat (4) @(negedge clk);
      clk_SPI = 0;
    end
  endtask

  task automatic frame(input logic [16:0] v, input int nb, input logic en, input bit clash,
                       output int nv, output int ne, output int lat);
    int v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    lat = -1;
    @(negedge clk);
    ena = en;
    CS = 0;
    repeat (4) @(negedge clk);
    send_bits(v, nb - 1, 0);
    repeat (2) @(negedge clk);
    CS = 1;
    if (clash) clk_SPI = 1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && (frame_valid || frame_error)) lat = c;
    end
    clk_SPI = 0;
    ena = 1;
    repeat (4) @(negedge clk);
    nv = vcnt - v0;
    ne = ecnt - e0;
  endtask

  typedef struct {
    logic [16:0] v;
    int nb;
    logic en;
    int xv;
    int xe;
    logic [3:0] xa;
    logic [7:0] xd;
    logic [63:0] xdig;
    logic [16:0] xctl;
  } vec_t;

  localparam logic [63:0] D2 = 64'h0900_0000_0000_0005;

  vec_t vt[14];
  int nv, ne, lat, v0, e0;

  initial begin
    vt[0]  = '{17'h00C01, 16, 1'b1, 1, 0, 4'hC, 8'h01, 64'h0, 17'h00002};
    vt[1]  = '{17'h00105, 16, 1'b1, 1, 0, 4'h1, 8'h05, 64'h05, 17'h00002};
    vt[2]  = '{17'h00809, 16, 1'b1, 1, 0, 4'h8, 8'h09, D2, 17'h00002};
    vt[3]  = '{17'h00A0F, 15, 1'b1, 0, 1, 4'h8, 8'h09, D2, 17'h00002};
    vt[4]  = '{17'h00A0F, 17, 1'b1, 0, 1, 4'h8, 8'h09, D2, 17'h00002};
    vt[5]  = '{17'h00A0F, 16, 1'b0, 0, 0, 4'h8, 8'h09, D2, 17'h00002};
    vt[6]  = '{17'h00A0F, 16, 1'b1, 1, 0, 4'hA, 8'h0F, D2, 17'h001E2};
    vt[7]  = '{17'h0FA0A, 16, 1'b1, 1, 0, 4'hA, 8'h0A, D2, 17'h00142};
    vt[8]  = '{17'h00DFF, 16, 1'b1, 1, 0, 4'hD, 8'hFF, D2, 17'h00142};
    vt[9]  = '{17'h00E55, 16, 1'b1, 1, 0, 4'hE, 8'h55, D2, 17'h00142};
    vt[10] = '{17'h00901, 16, 1'b1, 1, 0, 4'h9, 8'h01, D2, 17'h00342};
    vt[11] = '{17'h00F01, 16, 1'b1, 1, 0, 4'hF, 8'h01, D2, 17'h00343};
    vt[12] = '{17'h00B07, 16, 1'b1, 1, 0, 4'hB, 8'h07, D2, 17'h0035F};
    vt[13] = '{17'h00000, 16, 1'b1, 1, 0, 4'h0, 8'h00, D2, 17'h0035F};

    repeat (3) @(negedge clk);
    chk("reset_digits", digits, 64'h0);
    chk("reset_ctl", 64'(ctl()), 64'h0);
    chk("reset_pulses", 64'({frame_valid, frame_error}), 64'h0);
    chk("reset_frame", 64'({frame_addr, frame_data}), 64'h0);
    res = 1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 14; k++) begin
      frame(vt[k].v, vt[k].nb, vt[k].en, 1'b0, nv, ne, lat);
      chk($sformatf("v%0d_valid_cnt", k), 64'(nv), 64'(vt[k].xv));
      chk($sformatf("v%0d_error_cnt", k), 64'(ne), 64'(vt[k].xe));
      chk($sformatf("v%0d_latency", k), 64'(lat), (vt[k].xv + vt[k].xe) > 0 ? 64'd3 : 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("v%0d_addr", k), 64'(frame_addr), 64'(vt[k].xa));
      chk($sformatf("v%0d_data", k), 64'(frame_data), 64'(vt[k].xd));
      chk($sformatf("v%0d_digits", k), digits, vt[k].xdig);
      chk($sformatf("v%0d_ctl", k), 64'(ctl()), 64'(vt[k].xctl));
    end

    v0 = vcnt;
    e0 = ecnt;
    @(negedge clk);
    CS = 0;
    repeat (4) @(negedge clk);
    send_bits(17'h00B07, 15, 8);
    res = 0;
    #1;
    chk("midreset_digits", digits, 64'h0);
    chk("midreset_ctl", 64'(ctl()), 64'h0);
    repeat (2) @(negedge clk);
    res = 1;
    send_bits(17'h00B07, 7, 0);
    repeat (2) @(negedge clk);
    CS = 1;
    repeat (12) @(negedge clk);
    chk("midreset_no_valid", 64'(vcnt - v0), 64'h0);
    chk("midreset_no_error", 64'(ecnt - e0), 64'h0);
    chk("midreset_scan_limit", 64'(scan_limit), 64'h0);
    chk("midreset_frame", 64'({frame_addr, frame_data}), 64'h0);

    frame(17'h00C01, 16, 1'b1, 1'b0, nv, ne, lat);
    chk("after_reset_valid", 64'(nv), 64'h1);
    chk("after_reset_ctl", 64'(ctl()), 64'h2);
    chk("after_reset_frame", 64'({frame_addr, frame_data}), 64'hC01);

    frame(17'h00103, 16, 1'b1, 1'b1, nv, ne, lat);
    chk("clash_valid", 64'(nv), 64'h1);
    chk("clash_error", 64'(ne), 64'h0);
    chk("clash_digits", digits, 64'h03);
    chk("clash_frame", 64'({frame_addr, frame_data}), 64'h103);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
